// File: rtl/sid_regfile.sv
// sid_regfile: SID-compatible register bank fed by the SPI slave, with per-voice gate edge pulses.
// Define SID_REGFILE_DBUF_EN to stage writes and commit them to the active bank on sample_tick_i.
module sid_regfile #(
    parameter int         NUM_VOICES     = 3,
    parameter logic [7:0] RDATA_UNMAPPED = 8'h00
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [6:0]  reg_addr_i,
    input  logic [7:0]  reg_wdata_i,
    input  logic        reg_we_i,
    output logic [7:0]  reg_rdata_o,
    input  logic        sample_tick_i,
    input  logic [7:0]  osc3_i,
    input  logic [7:0]  env3_i,
    output logic [47:0] freq_o,
    output logic [35:0] pw_o,
    output logic [23:0] ctrl_o,
    output logic [23:0] ad_o,
    output logic [23:0] sr_o,
    output logic [10:0] fc_o,
    output logic [3:0]  res_o,
    output logic [3:0]  route_o,
    output logic [3:0]  mode_o,
    output logic [3:0]  vol_o,
    output logic [2:0]  gate_rise_o,
    output logic [2:0]  gate_fall_o
);
    localparam int         NUM_REGS  = 25;
    localparam logic [6:0] ADDR_LAST = 7'h18;
    localparam logic [6:0] ADDR_OSC3 = 7'h1B;
    localparam logic [6:0] ADDR_ENV3 = 7'h1C;

    // The register map is the fixed SID layout; other voice counts have no meaning.
    if (NUM_VOICES != 3) begin : g_bad_voices
        $error("sid_regfile: NUM_VOICES must be 3");
    end

    function automatic logic [7:0] store_mask(input logic [4:0] idx, input logic [7:0] data);
        logic [7:0] m;
        m = data;
        if (idx == 5'd3 || idx == 5'd10 || idx == 5'd17) begin
            m = {4'h0, data[3:0]};
        end else if (idx == 5'd21) begin
            m = {5'h00, data[2:0]};
        end
        return m;
    endfunction

    function automatic logic [2:0] gates(input logic [NUM_REGS-1:0][7:0] bank);
        return {bank[18][0], bank[11][0], bank[4][0]};
    endfunction

    logic [NUM_REGS-1:0][7:0] active_q;
    logic [NUM_REGS-1:0][7:0] active_d;
    logic [NUM_REGS-1:0][7:0] read_bank;
    logic                     wr_en;
    logic [4:0]               wr_idx;
    logic [7:0]               wr_byte;
    logic [7:0]               rdata_d;
    logic [2:0]               gate_q;
    logic [2:0]               gate_d;

    assign wr_en   = reg_we_i && (reg_addr_i <= ADDR_LAST);
    assign wr_idx  = reg_addr_i[4:0];
    assign wr_byte = store_mask(wr_idx, reg_wdata_i);

`ifdef SID_REGFILE_DBUF_EN
    logic [NUM_REGS-1:0][7:0] stage_q;
    logic [NUM_REGS-1:0][7:0] stage_d;

    always_comb begin
        stage_d = stage_q;
        if (wr_en) begin
            stage_d[wr_idx] = wr_byte;
        end
    end

    // Commit takes stage_d so a write landing on the tick edge is included.
    always_comb begin
        active_d = active_q;
        if (sample_tick_i) begin
            active_d = stage_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign read_bank = stage_q;
`else
    logic tick_unused;
    assign tick_unused = sample_tick_i;

    always_comb begin
        active_d = active_q;
        if (wr_en) begin
            active_d[wr_idx] = wr_byte;
        end
    end

    assign read_bank = active_q;
`endif

    assign gate_q = gates(active_q);
    assign gate_d = gates(active_d);

    always_comb begin
        rdata_d = RDATA_UNMAPPED;
        if (reg_addr_i <= ADDR_LAST) begin
            rdata_d = read_bank[reg_addr_i[4:0]];
        end else if (reg_addr_i == ADDR_OSC3) begin
            rdata_d = osc3_i;
        end else if (reg_addr_i == ADDR_ENV3) begin
            rdata_d = env3_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            active_q    <= '0;
            reg_rdata_o <= 8'h00;
            gate_rise_o <= 3'b000;
            gate_fall_o <= 3'b000;
        end else begin
            active_q    <= active_d;
            reg_rdata_o <= rdata_d;
            gate_rise_o <= gate_d & ~gate_q;
            gate_fall_o <= ~gate_d & gate_q;
        end
    end

    for (genvar v = 0; v < 3; v++) begin : g_voice
        assign freq_o[16*v +: 16] = {active_q[7*v+1], active_q[7*v]};
        assign pw_o[12*v +: 12]   = {active_q[7*v+3][3:0], active_q[7*v+2]};
        assign ctrl_o[8*v +: 8]   = active_q[7*v+4];
        assign ad_o[8*v +: 8]     = active_q[7*v+5];
        assign sr_o[8*v +: 8]     = active_q[7*v+6];
    end

    assign fc_o    = {active_q[22], active_q[21][2:0]};
    assign res_o   = active_q[23][7:4];
    assign route_o = active_q[23][3:0];
    assign mode_o  = active_q[24][7:4];
    assign vol_o   = active_q[24][3:0];

endmodule

// File: tb/tb_sid_regfile.sv
// tb_sid_regfile: randomized and directed checks of sid_regfile against a byte-array register model.
// Follows the build: honours SID_REGFILE_DBUF_EN the same way the design does.
module tb_sid_regfile;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [6:0]  reg_addr_i = '0;
    logic [7:0]  reg_wdata_i = '0;
    logic        reg_we_i = 1'b0;
    logic [7:0]  reg_rdata_o;
    logic        sample_tick_i = 1'b0;
    logic [7:0]  osc3_i = 8'hA5;
    logic [7:0]  env3_i = 8'h3C;
    logic [47:0] freq_o;
    logic [35:0] pw_o;
    logic [23:0] ctrl_o, ad_o, sr_o;
    logic [10:0] fc_o;
    logic [3:0]  res_o, route_o, mode_o, vol_o;
    logic [2:0]  gate_rise_o, gate_fall_o;

`ifdef SID_REGFILE_DBUF_EN
    localparam bit DBUF = 1'b1;
`else
    localparam bit DBUF = 1'b0;
`endif

    sid_regfile dut (
        .clk_i(clk_i), .rst_i(rst_i), .reg_addr_i(reg_addr_i), .reg_wdata_i(reg_wdata_i),
        .reg_we_i(reg_we_i), .reg_rdata_o(reg_rdata_o), .sample_tick_i(sample_tick_i),
        .osc3_i(osc3_i), .env3_i(env3_i), .freq_o(freq_o), .pw_o(pw_o), .ctrl_o(ctrl_o),
        .ad_o(ad_o), .sr_o(sr_o), .fc_o(fc_o), .res_o(res_o), .route_o(route_o),
        .mode_o(mode_o), .vol_o(vol_o), .gate_rise_o(gate_rise_o), .gate_fall_o(gate_fall_o)
    );

    always #10 clk_i = ~clk_i;

    logic [7:0] stg [25];
    logic [7:0] act [25];
    logic [7:0] exp_rdata;
    logic [2:0] exp_rise, exp_fall;
    int checks = 0;
    int errors = 0;

    function automatic logic [2:0] model_gates();
        return {act[18][0], act[11][0], act[4][0]};
    endfunction

    function automatic logic [7:0] model_read(input logic [6:0] a);
        if (a <= 7'h18) return DBUF ? stg[int'(a)] : act[int'(a)];
        if (a == 7'h1B) return osc3_i;
        if (a == 7'h1C) return env3_i;
        return 8'h00;
    endfunction

    function automatic logic [47:0] m_freq();
        logic [47:0] r;
        for (int v = 0; v < 3; v++) r[16*v +: 16] = {act[7*v+1], act[7*v]};
        return r;
    endfunction

    function automatic logic [35:0] m_pw();
        logic [35:0] r;
        for (int v = 0; v < 3; v++) r[12*v +: 12] = {act[7*v+3][3:0], act[7*v+2]};
        return r;
    endfunction

    function automatic logic [23:0] m_byte3(input int off);
        return {act[14+off], act[7+off], act[off]};
    endfunction

    // One clock: drive at negedge, apply the register rules at the edge, settle 1 unit after.
    task automatic step(input logic rst, input logic we, input logic [6:0] addr,
                        input logic [7:0] wd, input logic tick);
        logic [2:0] g_old, g_new;
        logic [7:0] v;
        @(negedge clk_i);
        rst_i = rst; reg_we_i = we; reg_addr_i = addr; reg_wdata_i = wd; sample_tick_i = tick;
        @(posedge clk_i);
        if (rst) begin
            for (int i = 0; i < 25; i++) begin stg[i] = 8'h00; act[i] = 8'h00; end
            exp_rdata = 8'h00; exp_rise = 3'b000; exp_fall = 3'b000;
        end else begin
            exp_rdata = model_read(addr);
            g_old = model_gates();
            if (we && addr <= 7'h18) begin
                v = wd;
                if (addr == 7'd3 || addr == 7'd10 || addr == 7'd17) v = v & 8'h0F;
                if (addr == 7'h15) v = v & 8'h07;
                if (DBUF) stg[int'(addr)] = v;
                else act[int'(addr)] = v;
            end
            if (DBUF && tick) for (int i = 0; i < 25; i++) act[i] = stg[i];
            g_new = model_gates();
            exp_rise = g_new & ~g_old;
            exp_fall = ~g_new & g_old;
        end
        #1;
    endtask

    task automatic test_reset();
        logic [7:0] want;
        osc3_i = 8'hA5; env3_i = 8'h3C;
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        checks++; if (freq_o !== 48'h0 || pw_o !== 36'h0 || ctrl_o !== 24'h0 || vol_o !== 4'h0) begin
            errors++; $display("FAIL reset_outputs: freq=%h pw=%h ctrl=%h vol=%h, want all 0", freq_o, pw_o, ctrl_o, vol_o); end
        checks++; if (gate_rise_o !== 3'b000 || gate_fall_o !== 3'b000 || reg_rdata_o !== 8'h00) begin
            errors++; $display("FAIL reset_pulses: rise=%b fall=%b rdata=%h, want 0", gate_rise_o, gate_fall_o, reg_rdata_o); end
        for (int a = 0; a <= 28; a++) begin
            step(0, 0, 7'(a), 0, 0);
            want = (a == 27) ? 8'hA5 : (a == 28) ? 8'h3C : 8'h00;
            checks++; if (reg_rdata_o !== want) begin
                errors++; $display("FAIL reset_read[%0h]: got %h want %h", a, reg_rdata_o, want); end
        end
    endtask

    task automatic test_freq();
        step(0, 1, 7'h00, 8'h34, 0);
        step(0, 1, 7'h01, 8'h12, 0);
        step(0, 0, 7'h01, 0, 0);
        checks++; if (freq_o[15:0] !== m_freq()[15:0]) begin
            errors++; $display("FAIL freq_pre_tick: got %h want %h", freq_o[15:0], m_freq()[15:0]); end
        checks++; if (reg_rdata_o !== 8'h12) begin
            errors++; $display("FAIL freq_read01: got %h want 12", reg_rdata_o); end
        step(0, 0, 7'h00, 0, 1);
        checks++; if (freq_o[15:0] !== 16'h1234) begin
            errors++; $display("FAIL freq_post_tick: got %h want 1234", freq_o[15:0]); end
    endtask

    task automatic test_mask();
        step(0, 1, 7'h03, 8'hFF, 0);
        step(0, 1, 7'h15, 8'hFF, 0);
        step(0, 1, 7'h16, 8'hAB, 0);
        step(0, 0, 7'h03, 0, 1);
        checks++; if (pw_o[11:0] !== 12'hF00 || fc_o !== 11'h55F) begin
            errors++; $display("FAIL mask_outputs: pw=%h fc=%h want F00 55F", pw_o[11:0], fc_o); end
        checks++; if (reg_rdata_o !== 8'h0F) begin
            errors++; $display("FAIL mask_read03: got %h want 0F", reg_rdata_o); end
        step(0, 0, 7'h15, 0, 0);
        checks++; if (reg_rdata_o !== 8'h07) begin
            errors++; $display("FAIL mask_read15: got %h want 07", reg_rdata_o); end
    endtask

    task automatic test_gate();
        step(0, 1, 7'h0B, 8'h01, 1);
        checks++; if (ctrl_o[15:8] !== 8'h01 || gate_rise_o !== 3'b010 || gate_fall_o !== 3'b000) begin
            errors++; $display("FAIL gate_rise: ctrl=%h rise=%b fall=%b want 01 010 000", ctrl_o[15:8], gate_rise_o, gate_fall_o); end
        step(0, 0, 7'h00, 0, 0);
        checks++; if (gate_rise_o !== 3'b000) begin
            errors++; $display("FAIL gate_width: rise=%b want 000", gate_rise_o); end
        step(0, 1, 7'h0B, 8'h00, 0);
        checks++; if (gate_fall_o !== exp_fall || gate_rise_o !== exp_rise) begin
            errors++; $display("FAIL gate_toggle0: rise=%b fall=%b want %b %b", gate_rise_o, gate_fall_o, exp_rise, exp_fall); end
        step(0, 1, 7'h0B, 8'h01, 0);
        checks++; if (gate_fall_o !== exp_fall || gate_rise_o !== exp_rise) begin
            errors++; $display("FAIL gate_toggle1: rise=%b fall=%b want %b %b", gate_rise_o, gate_fall_o, exp_rise, exp_fall); end
        step(0, 0, 7'h00, 0, 1);
        checks++; if (gate_rise_o !== 3'b000 || gate_fall_o !== 3'b000) begin
            errors++; $display("FAIL gate_no_pulse: rise=%b fall=%b want 000 000", gate_rise_o, gate_fall_o); end
    endtask

    task automatic test_unmapped();
        step(0, 1, 7'h1F, 8'h77, 0);
        step(0, 1, 7'h19, 8'h55, 0);
        step(0, 0, 7'h1F, 0, 0);
        checks++; if (reg_rdata_o !== 8'h00) begin
            errors++; $display("FAIL unmapped_read1F: got %h want 00", reg_rdata_o); end
        step(0, 0, 7'h19, 0, 1);
        checks++; if (reg_rdata_o !== 8'h00) begin
            errors++; $display("FAIL unmapped_read19: got %h want 00", reg_rdata_o); end
        checks++; if (freq_o !== m_freq() || pw_o !== m_pw() || ctrl_o !== m_byte3(4)) begin
            errors++; $display("FAIL unmapped_state: freq=%h pw=%h ctrl=%h want %h %h %h",
                               freq_o, pw_o, ctrl_o, m_freq(), m_pw(), m_byte3(4)); end
    endtask

    task automatic test_reset_mid();
        step(0, 1, 7'h04, 8'h01, 0);
        step(0, 1, 7'h12, 8'h41, 0);
        step(1, 0, 7'h00, 0, 0);
        step(0, 0, 7'h04, 0, 1);
        checks++; if (ctrl_o !== 24'h0 || freq_o !== 48'h0 || gate_rise_o !== 3'b000 || gate_fall_o !== 3'b000) begin
            errors++; $display("FAIL reset_mid: ctrl=%h freq=%h rise=%b fall=%b want 0", ctrl_o, freq_o, gate_rise_o, gate_fall_o); end
        checks++; if (reg_rdata_o !== 8'h00) begin
            errors++; $display("FAIL reset_mid_read04: got %h want 00", reg_rdata_o); end
    endtask

    task automatic test_vol();
        step(0, 1, 7'h18, 8'h1F, 0);
        step(0, 0, 7'h18, 0, 0);
        checks++; if (vol_o !== act[24][3:0] || mode_o !== act[24][7:4]) begin
            errors++; $display("FAIL vol_pre_tick: vol=%h mode=%h want %h %h", vol_o, mode_o, act[24][3:0], act[24][7:4]); end
        checks++; if (reg_rdata_o !== 8'h1F) begin
            errors++; $display("FAIL vol_read18: got %h want 1F", reg_rdata_o); end
        step(0, 0, 7'h00, 0, 1);
        checks++; if (vol_o !== 4'hF || mode_o !== 4'h1) begin
            errors++; $display("FAIL vol_post_tick: vol=%h mode=%h want F 1", vol_o, mode_o); end
    endtask

    task automatic test_random();
        logic [6:0] a;
        for (int n = 0; n < 400; n++) begin
            osc3_i = 8'($urandom); env3_i = 8'($urandom);
            a = ($urandom_range(0, 9) < 8) ? 7'($urandom_range(0, 28)) : 7'($urandom_range(0, 127));
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 1) == 1), a, 8'($urandom),
                 ($urandom_range(0, 5) == 0));
            checks++; if (reg_rdata_o !== exp_rdata) begin
                errors++; $display("FAIL rnd_rdata[%0d]: got %h want %h", n, reg_rdata_o, exp_rdata); end
            checks++; if (gate_rise_o !== exp_rise || gate_fall_o !== exp_fall) begin
                errors++; $display("FAIL rnd_gate[%0d]: rise=%b fall=%b want %b %b", n, gate_rise_o, gate_fall_o, exp_rise, exp_fall); end
            checks++; if (freq_o !== m_freq() || pw_o !== m_pw()) begin
                errors++; $display("FAIL rnd_freq_pw[%0d]: %h %h want %h %h", n, freq_o, pw_o, m_freq(), m_pw()); end
            checks++; if (ctrl_o !== m_byte3(4) || ad_o !== m_byte3(5) || sr_o !== m_byte3(6)) begin
                errors++; $display("FAIL rnd_ctrl_adsr[%0d]: %h %h %h want %h %h %h", n, ctrl_o, ad_o, sr_o,
                                   m_byte3(4), m_byte3(5), m_byte3(6)); end
            checks++; if (fc_o !== {act[22], act[21][2:0]} || {res_o, route_o} !== act[23] || {mode_o, vol_o} !== act[24]) begin
                errors++; $display("FAIL rnd_filter[%0d]: fc=%h rr=%h mv=%h want %h %h %h", n, fc_o, {res_o, route_o},
                                   {mode_o, vol_o}, {act[22], act[21][2:0]}, act[23], act[24]); end
        end
    endtask

    initial begin
        for (int i = 0; i < 25; i++) begin stg[i] = 8'h00; act[i] = 8'h00; end
        test_reset();
        test_freq();
        test_mask();
        test_gate();
        test_unmapped();
        test_reset_mid();
        test_vol();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
